gpr_file_mp: RTL and testbench
==============================

// Module: gpr_file_mp
// PURPOSE
//  Parametrised MIPS general-purpose register file: NUM_REGS x DATA_W array with NUM_RD
//  combinational read ports, one write port, and optional write-through bypass.
//  Adds LO/HI special registers with separate write enables, plus a pending-operation
//  tracker for multi-cycle MULT/DIV. It raises stall when an MFHI/MFLO read hits an
//  outstanding result. Sits between decode (reads) and writeback (writes) in the core.
// PARAMETERS
//  DATA_W    32  register width in bits
//  NUM_REGS  32  architectural GPR count; power of two, >=2; register 0 reads as zero
//  NUM_RD    2   number of GPR read ports (1..4)
//  BYPASS    1   1 = same-cycle write data forwarded to reads; 0 = read old array value
//  MAX_PEND  3   maximum outstanding MULT/DIV ops tracked (counter width = clog2(MAX_PEND+1))
// PORTS
//  clk       in   1               clock; all state updates on the rising edge
//  rst       in   1               asynchronous, active-high reset
//  we        in   1               GPR write enable
//  waddr     in   AW              GPR write address (AW = clog2(NUM_REGS))
//  wdata     in   DATA_W          GPR write data
//  raddr     in   NUM_RD*AW       packed read addresses; port k = [k*AW +: AW]
//  rdata     out  NUM_RD*DATA_W   packed read data; port k = [k*DATA_W +: DATA_W]
//  lo_we     in   1               LO write enable (MTLO or MULT/DIV completion)
//  hi_we     in   1               HI write enable (MTHI or MULT/DIV completion)
//  lo_wdata  in   DATA_W          LO write data
//  hi_wdata  in   DATA_W          HI write data
//  md_start  in   1               multi-cycle MULT/DIV issued this cycle
//  md_done   in   1               MULT/DIV result valid this cycle (asserted with lo_we/hi_we)
//  mf_req    in   1               decode is reading LO or HI (MFLO/MFHI) this cycle
//  lo        out  DATA_W          LO value (bypassed when BYPASS=1)
//  hi        out  DATA_W          HI value (bypassed when BYPASS=1)
//  md_busy   out  1               pending count != 0
//  stall     out  1               hold decode: MF read of an unfinished result
//  err       out  1               sticky: counter overflow, or md_done with count 0
// BEHAVIOUR
//  - Reset (async, rst=1): every GPR, LO, HI = 0; pend_cnt = 0; err = 0.
//    Outputs while in reset: rdata 0 for all ports, lo = hi = 0, md_busy = stall = 0.
//  - Reset mid-operation discards every pending MULT/DIV. A md_done arriving after reset
//    release with count 0 sets err.
//  - Reads: zero-cycle combinational. Register 0 always reads 0; writes to it are dropped.
//  - Write: on posedge clk when we=1 and waddr!=0, array[waddr] <= wdata.
//  - Bypass (BYPASS=1): if we && waddr==raddr_k && waddr!=0, rdata_k = wdata in the same cycle.
//    - lo output = lo_wdata while lo_we=1; hi output = hi_wdata while hi_we=1.
//    - BYPASS=0: outputs always show registered contents.
//  - LO/HI: lo_we and hi_we are independent; both may fire in the same cycle.
//  - Pending counter:
//    - md_start alone: +1. md_done alone: -1. Both in one cycle: unchanged (back-to-back ops).
//    - md_start at count==MAX_PEND: count saturates and err <= 1.
//    - md_done at count==0: count stays 0 and err <= 1.
//    - lo_we/hi_we without md_done (MTLO/MTHI) never change the count.
//  - stall = mf_req && pend_cnt!=0, except it is 0 when BYPASS=1 && md_done && pend_cnt==1
//    && !md_start (final result is forwarded this cycle). Purely combinational, no latency.
//  - err clears only on reset.
// STRUCTURE
//  - Shared package gpr_pkg:
//    - clog2 function.
//    - register index constants: REG_ZERO=0, REG_RA=31.
//    - DATA_W default constant.
//  - One sub-module gpr_md_tracker: pend_cnt, saturation, err and stall logic.
//    Ports: clk, rst, md_start, md_done, mf_req, md_busy, stall, err.
//  - Top level: array, read muxes and bypass as generate loops over NUM_RD.
// TESTING
//  1. Assert rst mid-run, then release.
//     -> All rdata/lo/hi = 0 and md_busy = stall = err = 0, both during rst and after release.
//  2. Write 0xDEADBEEF to r5, then read r5 on port 1 in the same cycle.
//     -> BYPASS=1: 0xDEADBEEF that cycle. BYPASS=0: old value (0); 0xDEADBEEF next cycle.
//  3. Write 0x12345678 to r0, then read r0 on all ports.
//     -> 0 on every port, in the same cycle and on later cycles.
//  4. md_start, 3 idle cycles with mf_req=1, then md_done with lo_wdata=0x0000_0010.
//     -> stall=1 for those 3 cycles; at md_done stall=0 and lo=0x10; md_busy=0 after.
//  5. md_start and md_done in the same cycle at count 1 -> count stays 1, md_busy=1.
//     Then 3 more md_start with MAX_PEND=3 -> count=3 and err=1 (sticky).
//  6. MTHI only: hi_we=1, hi_wdata=0xCAFEF00D, md_done=0, count 0.
//     -> hi=0xCAFEF00D, lo unchanged, pend_cnt 0, err 0.
//     Then md_done alone with count 0 -> err=1.

Source files
------------

// File: rtl/gpr_pkg.sv
// Shared definitions for the MIPS GPR file slice.
//   GPR_DATA_W : default register width
//   REG_ZERO   : hard-wired zero register index
//   REG_RA     : return-address register index
//   clog2()    : elaboration-time ceiling log2
package gpr_pkg;

  localparam int GPR_DATA_W = 32;
  localparam int REG_ZERO   = 0;
  localparam int REG_RA     = 31;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/gpr_md_tracker.sv
// Outstanding MULT/DIV tracker: counts issued-but-unfinished operations,
// flags over/underflow (sticky) and stalls MFHI/MFLO reads of unfinished results.
//   clk, rst   : clock, async active-high reset
//   md_start   : operation issued this cycle
//   md_done    : operation result valid this cycle
//   mf_req     : decode reads LO/HI this cycle
//   md_busy    : at least one operation outstanding
//   stall      : hold decode (combinational)
//   err        : sticky overflow / spurious-completion flag
module gpr_md_tracker
  import gpr_pkg::*;
#(
  parameter int MAX_PEND = 3,
  parameter bit BYPASS   = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic md_start,
  input  logic md_done,
  input  logic mf_req,
  output logic md_busy,
  output logic stall,
  output logic err
);

  localparam int CW = clog2(MAX_PEND + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_PEND);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [CW-1:0] pend_cnt;
  logic          fwd_final;

  // A start and a done in the same cycle cancel out, so neither bound is hit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_cnt <= '0;
      err      <= 1'b0;
    end else if (md_start && !md_done) begin
      if (pend_cnt == CNT_MAX) err <= 1'b1;
      else                     pend_cnt <= pend_cnt + CNT_ONE;
    end else if (md_done && !md_start) begin
      if (pend_cnt == '0) err <= 1'b1;
      else                pend_cnt <= pend_cnt - CNT_ONE;
    end
  end

  // Last outstanding result is forwarded onto lo/hi this cycle, so the read may proceed.
  assign fwd_final = BYPASS && md_done && !md_start && (pend_cnt == CNT_ONE);
  assign md_busy   = (pend_cnt != '0);
  assign stall     = mf_req && md_busy && !fwd_final;

endmodule

// File: rtl/gpr_file_mp.sv
// Multi-port MIPS general-purpose register file with LO/HI and MULT/DIV tracking.
//   clk, rst            : clock, async active-high reset
//   we, waddr, wdata    : GPR write port (writes to register 0 dropped)
//   raddr, rdata        : NUM_RD packed combinational read ports
//   lo_we/hi_we, *_wdata: LO/HI write ports (independent)
//   md_start, md_done   : MULT/DIV issue / completion
//   mf_req              : MFLO/MFHI read this cycle
//   lo, hi              : LO/HI values (forwarded when BYPASS=1)
//   md_busy, stall, err : tracker status
module gpr_file_mp
  import gpr_pkg::*;
#(
  parameter int DATA_W   = GPR_DATA_W,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2,
  parameter bit BYPASS   = 1'b1,
  parameter int MAX_PEND = 3,
  localparam int AW      = clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [AW-1:0]            waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [NUM_RD*AW-1:0]     raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  input  logic                     lo_we,
  input  logic                     hi_we,
  input  logic [DATA_W-1:0]        lo_wdata,
  input  logic [DATA_W-1:0]        hi_wdata,
  input  logic                     md_start,
  input  logic                     md_done,
  input  logic                     mf_req,
  output logic [DATA_W-1:0]        lo,
  output logic [DATA_W-1:0]        hi,
  output logic                     md_busy,
  output logic                     stall,
  output logic                     err
);

  logic [DATA_W-1:0] mem [NUM_REGS];
  logic [DATA_W-1:0] lo_q;
  logic [DATA_W-1:0] hi_q;
  logic              wr_ok;
  logic              byp_en;

  assign wr_ok  = we && (waddr != AW'(REG_ZERO));
  // Forwarding is suppressed in reset so every output reads zero while rst is high.
  assign byp_en = BYPASS && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
    end else if (wr_ok) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lo_q <= '0;
      hi_q <= '0;
    end else begin
      if (lo_we) lo_q <= lo_wdata;
      if (hi_we) hi_q <= hi_wdata;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0]     ra;
    logic [DATA_W-1:0] rv;

    assign ra = raddr[k*AW +: AW];

    always_comb begin
      rv = mem[ra];
      if (ra == AW'(REG_ZERO))               rv = '0;
      else if (byp_en && wr_ok && waddr == ra) rv = wdata;
    end

    assign rdata[k*DATA_W +: DATA_W] = rv;
  end

  assign lo = (byp_en && lo_we) ? lo_wdata : lo_q;
  assign hi = (byp_en && hi_we) ? hi_wdata : hi_q;

  gpr_md_tracker #(
    .MAX_PEND (MAX_PEND),
    .BYPASS   (BYPASS)
  ) u_md_tracker (
    .clk      (clk),
    .rst      (rst),
    .md_start (md_start),
    .md_done  (md_done),
    .mf_req   (mf_req),
    .md_busy  (md_busy),
    .stall    (stall),
    .err      (err)
  );

endmodule

// File: tb/tb_gpr_file_mp.sv
module tb_gpr_file_mp;
  import gpr_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0;
  logic [4:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic [9:0]  raddr = '0;
  logic        lo_we = 1'b0, hi_we = 1'b0;
  logic [31:0] lo_wdata = '0, hi_wdata = '0;
  logic        md_start = 1'b0, md_done = 1'b0, mf_req = 1'b0;

  logic [63:0] b_rdata, n_rdata;
  logic [31:0] b_lo, b_hi, n_lo, n_hi;
  logic        b_busy, b_stall, b_err, n_busy, n_stall, n_err;

  int total = 0;
  int bad   = 0;
  bit running = 1'b0;

  always #5 clk = ~clk;

  gpr_file_mp #(.DATA_W(32), .NUM_REGS(32), .NUM_RD(2), .BYPASS(1'b1), .MAX_PEND(3)) u_dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .raddr(raddr), .rdata(b_rdata),
    .lo_we(lo_we), .hi_we(hi_we), .lo_wdata(lo_wdata), .hi_wdata(hi_wdata),
    .md_start(md_start), .md_done(md_done), .mf_req(mf_req),
    .lo(b_lo), .hi(b_hi), .md_busy(b_busy), .stall(b_stall), .err(b_err));

  gpr_file_mp #(.DATA_W(32), .NUM_REGS(32), .NUM_RD(2), .BYPASS(1'b0), .MAX_PEND(3)) u_dut_nb (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .raddr(raddr), .rdata(n_rdata),
    .lo_we(lo_we), .hi_we(hi_we), .lo_wdata(lo_wdata), .hi_wdata(hi_wdata),
    .md_start(md_start), .md_done(md_done), .mf_req(mf_req),
    .lo(n_lo), .hi(n_hi), .md_busy(n_busy), .stall(n_stall), .err(n_err));

  // Architectural model: register contents, LO/HI, number of outstanding ops, error flag.
  logic [31:0] m_regs [32] = '{default: '0};
  logic [31:0] m_lo = '0, m_hi = '0;
  int          m_cnt = 0;
  bit          m_err = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_lo = '0; m_hi = '0; m_cnt = 0; m_err = 1'b0;
    end else begin
      if (we && waddr != 5'd0) m_regs[waddr] = wdata;
      if (lo_we) m_lo = lo_wdata;
      if (hi_we) m_hi = hi_wdata;
      if (md_start && !md_done) begin
        if (m_cnt == 3) m_err = 1'b1; else m_cnt = m_cnt + 1;
      end else if (md_done && !md_start) begin
        if (m_cnt == 0) m_err = 1'b1; else m_cnt = m_cnt - 1;
      end
    end
  end

  function automatic logic [63:0] exp_rdata(input bit bp);
    logic [63:0] r;
    logic [4:0]  a;
    logic [31:0] v;
    r = '0;
    for (int k = 0; k < 2; k++) begin
      a = raddr[k*5 +: 5];
      if (rst || a == 5'd0)              v = '0;
      else if (bp && we && waddr == a)   v = wdata;
      else                               v = m_regs[a];
      r[k*32 +: 32] = v;
    end
    return r;
  endfunction

  function automatic logic [31:0] exp_lohi(input bit bp, input bit wen, input logic [31:0] wd,
                                           input logic [31:0] cur);
    if (rst)            return '0;
    if (bp && wen)      return wd;
    return cur;
  endfunction

  function automatic bit exp_stall(input bit bp);
    if (rst || !mf_req || m_cnt == 0) return 1'b0;
    if (bp && md_done && !md_start && m_cnt == 1) return 1'b0;
    return 1'b1;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (running) begin
      chk("cyc_rdata_byp", b_rdata, exp_rdata(1'b1));
      chk("cyc_rdata_nob", n_rdata, exp_rdata(1'b0));
      chk("cyc_lo_byp", b_lo, exp_lohi(1'b1, lo_we, lo_wdata, m_lo));
      chk("cyc_lo_nob", n_lo, exp_lohi(1'b0, lo_we, lo_wdata, m_lo));
      chk("cyc_hi_byp", b_hi, exp_lohi(1'b1, hi_we, hi_wdata, m_hi));
      chk("cyc_hi_nob", n_hi, exp_lohi(1'b0, hi_we, hi_wdata, m_hi));
      chk("cyc_busy_byp", b_busy, (m_cnt != 0));
      chk("cyc_busy_nob", n_busy, (m_cnt != 0));
      chk("cyc_stall_byp", b_stall, exp_stall(1'b1));
      chk("cyc_stall_nob", n_stall, exp_stall(1'b0));
      chk("cyc_err_byp", b_err, m_err);
      chk("cyc_err_nob", n_err, m_err);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0; lo_we = 1'b0; hi_we = 1'b0;
    md_start = 1'b0; md_done = 1'b0; mf_req = 1'b0;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_rdata_b"}, b_rdata, 64'h0);
    chk({nm, "_rdata_n"}, n_rdata, 64'h0);
    chk({nm, "_lohi_b"}, {b_lo, b_hi}, 64'h0);
    chk({nm, "_lohi_n"}, {n_lo, n_hi}, 64'h0);
    chk({nm, "_status_b"}, {b_busy, b_stall, b_err}, 64'h0);
    chk({nm, "_status_n"}, {n_busy, n_stall, n_err}, 64'h0);
  endtask

  initial begin
    running = 1'b1;
    repeat (2) tick();
    rst = 1'b0;

    // 1: build up state, then reset mid-cycle with a write and MF read pending
    we = 1'b1; waddr = 5'd5; wdata = 32'h1111_2222;
    lo_we = 1'b1; lo_wdata = 32'hAAAA_5555; md_start = 1'b1;
    tick();
    idle();
    raddr = {5'd5, 5'd5};
    mf_req = 1'b1;
    #1 chk("pre_rst_stall", b_stall, 1'b1);
    chk("pre_rst_r5", b_rdata, {2{32'h1111_2222}});
    #1 rst = 1'b1;
    we = 1'b1; waddr = 5'd5; wdata = 32'h7777_7777;
    #1 chk_all_zero("in_rst");
    tick();
    #2 chk_all_zero("in_rst2");
    idle();
    rst = 1'b0;
    #1 chk_all_zero("post_rst");
    tick();

    // 2: write r5 and read it on port 1 in the same cycle
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEAD_BEEF; raddr = {5'd5, 5'd0};
    #2 chk("byp_same_cycle", b_rdata[63:32], 32'hDEAD_BEEF);
    chk("nob_same_cycle", n_rdata[63:32], 32'h0);
    tick();
    idle();
    #2 chk("nob_next_cycle", n_rdata[63:32], 32'hDEAD_BEEF);
    chk("byp_next_cycle", b_rdata[63:32], 32'hDEAD_BEEF);

    // 3: writes to r0 are dropped
    tick();
    we = 1'b1; waddr = 5'd0; wdata = 32'h1234_5678; raddr = {5'd0, 5'd0};
    #2 chk("r0_same_b", b_rdata, 64'h0);
    chk("r0_same_n", n_rdata, 64'h0);
    tick();
    idle();
    #2 chk("r0_later_b", b_rdata, 64'h0);

    // r31 on port 0 alongside r5 on port 1
    tick();
    we = 1'b1; waddr = 5'(REG_RA); wdata = 32'h0BAD_F00D; raddr = {5'd5, 5'(REG_RA)};
    tick();
    idle();
    #2 chk("r31_r5_n", n_rdata, {32'hDEAD_BEEF, 32'h0BAD_F00D});

    // 4: one MULT/DIV with MFLO waiting on it
    tick();
    md_start = 1'b1;
    tick();
    idle();
    mf_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2 chk("md_wait_stall", {b_stall, n_stall}, 2'b11);
      tick();
    end
    md_done = 1'b1; lo_we = 1'b1; lo_wdata = 32'h0000_0010;
    #2 chk("md_done_byp", {b_stall, b_lo}, {1'b0, 32'h10});
    chk("md_done_nob", {n_stall, n_lo}, {1'b1, 32'h0});
    tick();
    idle();
    #2 chk("md_after", {b_busy, n_busy, b_lo, n_lo}, {2'b00, 32'h10, 32'h10});

    // 5: back-to-back start/done, then overflow past MAX_PEND
    tick();
    md_start = 1'b1;
    tick();
    md_start = 1'b1; md_done = 1'b1;
    tick();
    idle();
    #2 chk("b2b_busy", {b_busy, b_err}, 2'b10);
    md_start = 1'b1;
    repeat (3) tick();
    idle();
    #2 chk("ovf_err", {b_busy, b_err, n_err}, 3'b111);
    md_done = 1'b1;
    tick();
    tick();
    #2 chk("sat_one_left", b_busy, 1'b1);
    tick();
    idle();
    #2 chk("sat_drained", {b_busy, b_err}, 2'b01);

    // 6: MTHI only, then spurious md_done
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    hi_we = 1'b1; hi_wdata = 32'hCAFE_F00D;
    #2 chk("mthi_byp", b_hi, 32'hCAFE_F00D);
    chk("mthi_nob", n_hi, 32'h0);
    tick();
    idle();
    #2 chk("mthi_after", {b_hi, n_lo}, {32'hCAFE_F00D, 32'h0});
    chk("mthi_status", {b_busy, b_err}, 2'b00);
    md_done = 1'b1;
    tick();
    idle();
    #2 chk("spurious_done", {b_busy, b_err, n_err}, 3'b011);

    // LO and HI written together
    lo_we = 1'b1; hi_we = 1'b1; lo_wdata = 32'h0101_0101; hi_wdata = 32'h0202_0202;
    tick();
    idle();
    #2 chk("lohi_both", {n_lo, n_hi}, {32'h0101_0101, 32'h0202_0202});

    tick();
    running = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
